// File: rtl/array_rw_pkg.sv
// rtl/array_rw_pkg.sv - shared geometry defaults and FSM state type for the SRAM requester
package array_rw_pkg;
  localparam int DEPTH    = 128;
  localparam int ADDR_W   = 7;
  localparam int WIDTH    = 1316;
  localparam int MASK_SEG = 4;
  localparam int GRAN     = 329;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/rw_resp_queue.sv
// rtl/rw_resp_queue.sv - 2-entry read response FIFO; pointers and count reset, storage does not
module rw_resp_queue #(
  parameter int WIDTH = 1316
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [1:0]       o_occ,
  output logic [WIDTH-1:0] o_head
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_occ  = r_count;
  assign o_head = r_mem[r_rd_ptr];
endmodule

// File: rtl/array_rw_requester.sv
// rtl/array_rw_requester.sv - zero-fills the SRAM after reset, then drives RW0 from valid/ready requests
module array_rw_requester #(
  parameter int DEPTH    = array_rw_pkg::DEPTH,
  parameter int ADDR_W   = array_rw_pkg::ADDR_W,
  parameter int WIDTH    = array_rw_pkg::WIDTH,
  parameter int MASK_SEG = array_rw_pkg::MASK_SEG,
  parameter int GRAN     = array_rw_pkg::GRAN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [MASK_SEG-1:0] req_mask,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WIDTH-1:0]    resp_rdata,
  output logic                init_done,
  output logic                RW0_clk,
  output logic [ADDR_W-1:0]   RW0_addr,
  output logic                RW0_en,
  output logic                RW0_wmode,
  output logic [MASK_SEG-1:0] RW0_wmask,
  output logic [WIDTH-1:0]    RW0_wdata,
  input  logic [WIDTH-1:0]    RW0_rdata
);
  import array_rw_pkg::*;

  if (WIDTH != MASK_SEG * GRAN) begin : g_bad_geometry
    $error("array_rw_requester: WIDTH must equal MASK_SEG*GRAN");
  end

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_init_addr;
  logic              r_inflight;
  logic [1:0]        w_occ;
  logic              w_pop;
  logic [2:0]        w_credit;
  logic              w_read_ok;
  logic              w_req_ready;
  logic              w_accept_read;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_inflight <= w_accept_read;
      if (r_state == INIT) r_init_addr <= r_init_addr + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == INIT && r_init_addr == ADDR_W'(DEPTH - 1)) w_next_state = RUN;
  end

  // A read is safe if the slots it could still need (queue + inflight) stay below 2 after this cycle's pop.
  assign w_pop     = resp_valid && resp_ready;
  assign w_credit  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_read_ok = (w_credit < 3'd2);

  always_comb begin
    w_req_ready = 1'b0;
    RW0_en      = 1'b0;
    RW0_wmode   = 1'b0;
    RW0_wmask   = '0;
    RW0_addr    = '0;
    RW0_wdata   = '0;
    if (!reset) begin
      case (r_state)
        INIT: begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_wmask = '1;
          RW0_addr  = r_init_addr;
        end
        RUN: begin
          w_req_ready = req_write || w_read_ok;
          RW0_en      = req_valid && w_req_ready;
          RW0_wmode   = req_write;
          RW0_wmask   = req_write ? req_mask : '0;
          RW0_addr    = req_addr;
          RW0_wdata   = req_wdata;
        end
        default: ;
      endcase
    end
  end

  assign w_accept_read = RW0_en && !RW0_wmode && (r_state == RUN);

  rw_resp_queue #(.WIDTH(WIDTH)) u_resp_queue (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_push      (r_inflight),
    .i_push_data (RW0_rdata),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (resp_rdata)
  );

  assign resp_valid = (w_occ != 2'd0);
  assign req_ready  = w_req_ready;
  assign init_done  = (r_state == RUN);
  assign RW0_clk    = clock;
endmodule

// File: tb/tb_array_rw_requester.sv
// tb/tb_array_rw_requester.sv - directed self-checking bench with a behavioural masked-write SRAM
module tb_array_rw_requester;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [6:0]    req_addr;
  logic [3:0]    req_mask;
  logic [1315:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [1315:0] resp_rdata;
  logic          init_done, RW0_clk, RW0_en, RW0_wmode;
  logic [6:0]    RW0_addr;
  logic [3:0]    RW0_wmask;
  logic [1315:0] RW0_wdata, RW0_rdata;

  int checks = 0;
  int errors = 0;

  logic [1315:0] mem [128];
  logic [1315:0] garb;
  logic [1315:0] mexp;

  array_rw_requester dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done), .RW0_clk(RW0_clk), .RW0_addr(RW0_addr), .RW0_en(RW0_en),
    .RW0_wmode(RW0_wmode), .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [1315:0] patt(input logic [7:0] b);
    logic [1315:0] r;
    for (int i = 0; i < 1316; i++) r[i] = b[i % 8];
    return r;
  endfunction

  // Macro model: rdata is only meaningful the cycle after a read; otherwise it carries garbage.
  always @(posedge RW0_clk) begin
    if (RW0_en && RW0_wmode) begin
      for (int s = 0; s < 4; s++)
        if (RW0_wmask[s]) mem[RW0_addr][s*329 +: 329] <= RW0_wdata[s*329 +: 329];
      RW0_rdata <= garb;
    end else if (RW0_en) begin
      RW0_rdata <= mem[RW0_addr];
    end else begin
      RW0_rdata <= garb;
    end
  end

  task automatic set_req(input logic v, input logic w, input logic [6:0] a,
                         input logic [3:0] m, input logic [1315:0] d);
    req_valid = v; req_write = w; req_addr = a; req_mask = m; req_wdata = d;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 7'd0, 4'd0, '0);
  endtask

  task automatic test_reset();
    int n_ok;
    idle();
    resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
    checks++; if (RW0_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", RW0_en); end
    checks++; if (RW0_wmode !== 1'b0 || RW0_wmask !== 4'h0 || RW0_addr !== 7'd0)
      begin errors++; $display("FAIL rst_rw0_ctl got wmode %b mask %h addr %h want 0", RW0_wmode, RW0_wmask, RW0_addr); end
    checks++; if (RW0_wdata !== '0) begin errors++; $display("FAIL rst_wdata got nonzero want 0"); end
    set_req(1'b1, 1'b0, 7'd5, 4'hF, '0);
    reset = 1'b0;
    n_ok = 0;
    for (int i = 0; i < 128; i++) begin
      #1;
      if (RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_wmask === 4'hF && RW0_wdata === '0 &&
          RW0_addr === 7'(i) && init_done === 1'b0 && req_ready === 1'b0) n_ok++;
      @(negedge clock);
    end
    checks++; if (n_ok != 128) begin errors++; $display("FAIL sweep_writes got %0d want 128", n_ok); end
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_129 got %b want 1", init_done); end
    checks++; if (req_ready !== 1'b1 || RW0_en !== 1'b1 || RW0_wmode !== 1'b0 || RW0_addr !== 7'd5)
      begin errors++; $display("FAIL first_read_accept got rdy %b en %b wm %b addr %h want 1 1 0 05", req_ready, RW0_en, RW0_wmode, RW0_addr); end
    @(negedge clock); idle(); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd5_t1_valid got %b want 0", resp_valid); end
    @(negedge clock); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== '0)
      begin errors++; $display("FAIL rd5_data got valid %b data_nonzero %b want 1 0", resp_valid, |resp_rdata); end
    @(negedge clock); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd5_pop got %b want 0", resp_valid); end
  endtask

  task automatic test_write_read();
    set_req(1'b1, 1'b1, 7'h12, 4'hF, patt(8'hA5)); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr12_ready got %b want 1", req_ready); end
    @(negedge clock);
    set_req(1'b1, 1'b0, 7'h12, 4'hF, '0); #1;
    checks++; if (req_ready !== 1'b1 || RW0_wmask !== 4'h0)
      begin errors++; $display("FAIL rd12_accept got rdy %b mask %h want 1 0", req_ready, RW0_wmask); end
    @(negedge clock); idle(); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd12_t1 got %b want 0", resp_valid); end
    @(negedge clock); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== patt(8'hA5))
      begin errors++; $display("FAIL rd12_data got valid %b low %h want 1 a5a5", resp_valid, resp_rdata[15:0]); end
    @(negedge clock);
  endtask

  task automatic test_masked_write();
    set_req(1'b1, 1'b1, 7'd3, 4'b0101, '1);
    @(negedge clock);
    set_req(1'b1, 1'b0, 7'd3, 4'h0, '0);
    @(negedge clock); idle();
    @(negedge clock); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== mexp)
      begin errors++; $display("FAIL masked_data got valid %b seg0 %b seg1 %b want 1 ones zeros", resp_valid, &resp_rdata[328:0], |resp_rdata[657:329]); end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    set_req(1'b1, 1'b1, 7'd1, 4'hF, patt(8'h11)); @(negedge clock);
    set_req(1'b1, 1'b1, 7'd2, 4'hF, patt(8'h22)); @(negedge clock);
    resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 7'd1, 4'h0, '0); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_rd1 got %b want 1", req_ready); end
    @(negedge clock); set_req(1'b1, 1'b0, 7'd2, 4'h0, '0); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_rd2 got %b want 1", req_ready); end
    @(negedge clock); set_req(1'b1, 1'b0, 7'd3, 4'h0, '0); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_rd3_block got %b want 0", req_ready); end
    @(negedge clock); #1;
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== patt(8'h11))
      begin errors++; $display("FAIL bp_full got rdy %b valid %b low %h want 0 1 1111", req_ready, resp_valid, resp_rdata[15:0]); end
    @(negedge clock); resp_ready = 1'b1; #1;
    checks++; if (req_ready !== 1'b1 || resp_rdata !== patt(8'h11))
      begin errors++; $display("FAIL bp_release got rdy %b low %h want 1 1111", req_ready, resp_rdata[15:0]); end
    @(negedge clock); idle(); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== patt(8'h22))
      begin errors++; $display("FAIL bp_order2 got valid %b low %h want 1 2222", resp_valid, resp_rdata[15:0]); end
    @(negedge clock); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== mexp)
      begin errors++; $display("FAIL bp_order3 got valid %b low %h want 1 ffff", resp_valid, resp_rdata[15:0]); end
    @(negedge clock); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    int drops;
    int bad;
    drops = 0; bad = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_req(1'b1, 1'b1, 7'(10 + i), 4'hF, patt(8'(10 + i))); #1;
      if (req_ready !== 1'b1) drops++;
      @(negedge clock);
    end
    for (int j = 0; j < 22; j++) begin
      if (j < 20) set_req(1'b1, 1'b0, 7'(10 + j), 4'h0, '0);
      else idle();
      #1;
      if (j < 20 && req_ready !== 1'b1) drops++;
      if (j >= 2) begin
        if (resp_valid !== 1'b1 || resp_rdata !== patt(8'(10 + j - 2))) bad++;
      end else if (resp_valid !== 1'b0) bad++;
      @(negedge clock);
    end
    #1;
    checks++; if (drops != 0) begin errors++; $display("FAIL stream_ready_drops got %0d want 0", drops); end
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_responses got %0d bad want 0", bad); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_reset_mid();
    int n_ok;
    int stale;
    resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 7'd1, 4'h0, '0); @(negedge clock);
    set_req(1'b1, 1'b0, 7'd2, 4'h0, '0); @(negedge clock);
    idle(); #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", resp_valid); end
    reset = 1'b1; #1;
    checks++; if (resp_valid !== 1'b0 || RW0_en !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0)
      begin errors++; $display("FAIL mid_rst_outputs got valid %b en %b rdy %b done %b want 0 0 0 0", resp_valid, RW0_en, req_ready, init_done); end
    repeat (2) @(negedge clock);
    resp_ready = 1'b1;
    reset = 1'b0;
    n_ok = 0; stale = 0;
    for (int i = 0; i < 128; i++) begin
      #1;
      if (RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_addr === 7'(i) && RW0_wdata === '0) n_ok++;
      if (resp_valid !== 1'b0) stale++;
      @(negedge clock);
    end
    #1;
    checks++; if (n_ok != 128) begin errors++; $display("FAIL mid_sweep got %0d want 128", n_ok); end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale_resp got %0d want 0", stale); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_init_done got %b want 1", init_done); end
  endtask

  initial begin
    garb = patt(8'h3C);
    for (int i = 0; i < 128; i++) mem[i] = garb;
    RW0_rdata = garb;
    mexp = '0;
    mexp[328:0] = '1;
    mexp[986:658] = '1;
    test_reset();
    test_write_read();
    test_masked_write();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/array_rw_requester.md
# array_rw_requester

Initiator-side front end for a single-port, masked-write, one-cycle-read-latency SRAM macro: 128 deep, 1316 bits wide, 4 mask segments of 329 bits. It accepts valid/ready read/write requests and drives the macro's RW0 port. It captures read data in the only cycle it is valid and returns it through a 2-entry response queue with backpressure. After reset it zero-initialises the whole array before accepting traffic.

## Interface
- DEPTH, 128, number of macro words
- ADDR_W, 7, log2(DEPTH)
- WIDTH, 1316, word width
- MASK_SEG, 4, write-mask segments; WIDTH == MASK_SEG*GRAN is required (elaboration check)
- GRAN, 329, bits per mask segment
- clock  in  1  sole clock; also drives RW0_clk
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when valid && ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_mask  in  MASK_SEG  write segment enables; ignored on reads
- req_wdata  in  WIDTH  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes resp_rdata
- resp_rdata  out  WIDTH  read data, returned in request order
- init_done  out  1  high once the zero-fill sweep has finished
- RW0_clk  out  1  equals clock
- RW0_addr  out  ADDR_W  macro address
- RW0_en  out  1  macro enable
- RW0_wmode  out  1  1 = write
- RW0_wmask  out  MASK_SEG  macro write mask
- RW0_wdata  out  WIDTH  macro write data
- RW0_rdata  in  WIDTH  macro read data, valid only in the cycle after a read enable

## Operation
- **FSM states:** INIT, RUN. Reset enters INIT with init address counter 0.
- **INIT:**
  - Each cycle: RW0_en=1, wmode=1, wmask=all ones, wdata=0, addr=counter; counter increments.
  - After the write to DEPTH-1, transition to RUN; init_done goes 1 the next cycle and stays 1.
  - req_ready=0 throughout INIT.
- **RUN:**
  - RW0_* are combinational from the req_* inputs. RW0_en = req_valid && req_ready. wmode = req_write. wmask = req_mask for writes, 0 for reads.
- **Write acceptance:** req_ready=1 for writes. Mask bit i updates bits [i*GRAN +: GRAN] only. Writes produce no response.
- **Read acceptance:** gated by credit. `inflight` is a 1-bit flag, set in the cycle after an accepted read. `occ` is queue occupancy (0..2).
  - Read accepted iff occ + inflight − (resp_valid && resp_ready) < 2.
  - req_ready may depend on req_write and on resp_ready in the same cycle.
- **Capture:** when inflight=1, RW0_rdata is pushed into the queue at that cycle's clock edge. RW0_rdata is never sampled in any other cycle; it is garbage when no read was issued.
- **Queue:**
  - 2-entry FIFO; resp_valid = (occ != 0); resp_rdata = head entry.
  - Push and pop in the same cycle are legal. The credit rule guarantees no push when full and no pop when empty.
- **Ordering:** strictly in order. A read issued the cycle after a write to the same address returns the new data, since the macro commits the write at the edge.
- **Reset (any time, including mid-read or mid-sweep):** queue empty, inflight=0, occ=0, resp_valid=0, init_done=0, req_ready=0, RW0_en=0 after reset deassert edge handling; FSM restarts INIT at address 0. Pending responses are discarded.

## Timing
- Output values while reset is asserted: req_ready=0, resp_valid=0, init_done=0, RW0_en=0, RW0_wmode=0, RW0_wmask=0, RW0_addr=0, RW0_wdata=0.
- First INIT write is issued in the first cycle after reset deasserts.
- The sweep takes DEPTH cycles. init_done rises in cycle DEPTH+1 after deassert; the first request can be accepted in that same cycle.
- Read latency: accepted at cycle T, macro reads at edge T, data captured at edge T+1, resp_valid=1 in cycle T+2 (2 cycles).
- Sustained throughput is 1 read/cycle while resp_ready=1. With resp_ready=0, at most 2 reads are outstanding (queue + inflight), after which read req_ready=0.

## Structure
- Shared package `array_rw_pkg`: DEPTH/ADDR_W/WIDTH/MASK_SEG/GRAN defaults and the FSM state enum {INIT, RUN}.
- One sub-module `rw_resp_queue`: 2-entry, WIDTH-wide FIFO with push/pop/occ, async active-high reset of pointers and count (data storage is not reset).
- Top level holds the FSM, init counter, inflight flag, credit logic and RW0 muxing.

## Test plan
- **Reset then idle:** exactly 128 full-mask zero writes to addresses 0..127; init_done=1 at cycle 129; read of address 5 returns 0.
- **Write then read:** write addr 0x12, data all 0xA5 pattern, mask 4'b1111, then read 0x12 -> resp_valid 2 cycles after acceptance with the pattern; write immediately followed by read of the same address returns new data.
- **Masked write:** write addr 3, all-ones data, mask 4'b0101 -> read returns ones in bits [328:0] and [986:658], zeros elsewhere.
- **Backpressure:** resp_ready=0, stream reads of addresses 1, 2, 3 -> first two accepted, req_ready=0 for the third. Raising resp_ready pops addr 1 data and the third read is accepted in the same cycle. Order is 1, 2, 3.
- **Full-rate streaming:** resp_ready=1, 20 back-to-back reads -> req_ready never drops; 20 responses in order, one per cycle.
- **Reset mid-operation:** assert reset with 2 reads outstanding -> resp_valid drops immediately; no stale response after deassert; INIT sweep restarts at address 0.
